branch_hazard_scoreboard: RTL

BRANCH_HAZARD_SCOREBOARD -- requirements
Module: branch_hazard_scoreboard

---
 rtl/branch_hazard_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_hazard_scoreboard.sv
// Branch-aware hazard scoreboard: tracks in-flight writers after ID, stalls ID until a value is forwardable.
// Optional statistics (stall_cycles / stall_events) built only with BRANCH_HAZARD_STATS_EN defined.
module branch_hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic        id_use_ra,
  input  logic        id_use_rb,
  input  logic [2:0]  id_branch,
  input  logic        id_regwr,
  input  logic        id_memtoreg,
  input  logic [4:0]  id_rw,
  input  logic        flush,
  output logic        stall,
  output logic [2:0]  fwd_sel_a,
  output logic [2:0]  fwd_sel_b
`ifdef BRANCH_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] stall_events
`endif
);

  logic [DEPTH:1] r_valid;
  logic [DEPTH:1] r_regwr;
  logic [DEPTH:1] r_memtoreg;
  logic [4:0]     r_rw [1:DEPTH];

  logic       w_is_br;
  logic [4:0] w_src       [2];
  logic       w_use       [2];
  logic [2:0] w_hit_k     [2];
  logic       w_hit_load  [2];
  logic [2:0] w_base      [2];
  logic [2:0] w_req       [2];
  logic       w_src_stall [2];
  logic [2:0] w_sel       [2];
  logic       w_load_s1;

  always_comb begin
    w_is_br = (id_branch != 3'b000);
    w_src[0] = id_ra;
    w_src[1] = id_rb;
    w_use[0] = w_is_br ? 1'b1 : id_use_ra;
    w_use[1] = (id_branch == 3'b001 || id_branch == 3'b010) ? 1'b1 :
               (w_is_br ? 1'b0 : id_use_rb);
    for (int s = 0; s < 2; s++) begin
      w_hit_k[s]    = 3'd0;
      w_hit_load[s] = 1'b0;
      // Scan oldest to youngest so the youngest matching producer wins.
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_regwr[k] && (r_rw[k] != 5'd0) && (r_rw[k] == w_src[s])) begin
          w_hit_k[s]    = 3'(k);
          w_hit_load[s] = r_memtoreg[k];
        end
      end
      w_base[s] = w_hit_load[s] ? 3'(LOAD_READY) : 3'(ALU_READY);
      // Non-branch consumers need the value one stage later (in EX), so one stage earlier suffices.
      w_req[s] = (!w_is_br && (w_base[s] > 3'd1)) ? (w_base[s] - 3'd1) : w_base[s];
      w_src_stall[s] = w_use[s] && (w_src[s] != 5'd0) && (w_hit_k[s] != 3'd0) &&
                       (w_hit_k[s] < w_req[s]);
      w_sel[s] = (w_use[s] && (w_src[s] != 5'd0) && !w_src_stall[s]) ? w_hit_k[s] : 3'd0;
    end
  end

  assign stall     = id_valid && !flush && (w_src_stall[0] || w_src_stall[1]);
  assign fwd_sel_a = w_sel[0];
  assign fwd_sel_b = w_sel[1];
  assign w_load_s1 = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_regwr    <= '0;
      r_memtoreg <= '0;
      for (int k = 1; k <= DEPTH; k++) r_rw[k] <= 5'd0;
    end else begin
      r_valid    <= {r_valid[DEPTH-1:1], w_load_s1};
      r_regwr    <= {r_regwr[DEPTH-1:1], id_regwr};
      r_memtoreg <= {r_memtoreg[DEPTH-1:1], id_memtoreg};
      r_rw[1]    <= id_rw;
      for (int k = 2; k <= DEPTH; k++) r_rw[k] <= r_rw[k-1];
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  // state    | meaning
  // ST_RUN   | ID advancing; a stall here starts a new stall event
  // ST_STALL | ID held on the previous clock
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      stall_cycles <= 32'd0;
      stall_events <= 16'd0;
    end else begin
      r_state <= stall ? ST_STALL : ST_RUN;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (stall && (r_state == ST_RUN) && (stall_events != 16'hFFFF))
        stall_events <= stall_events + 16'd1;
    end
  end
`endif

endmodule
